// File: rtl/data_memory_moc_if.sv
// Request/response bundle between the control register and the data memory.
interface data_memory_moc_if;
  logic        mov;
  logic        rw;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        err;

  modport master (
    output mov, rw, size, sgn, address, data_in,
    input  data_out, moc, err
  );

  modport slave (
    input  mov, rw, size, sgn, address, data_in,
    output data_out, moc, err
  );
endinterface

// File: rtl/data_memory_moc.sv
// Byte-addressable big-endian data memory with a four-phase MOV/MOC handshake
// and a fixed access latency, so microcode wait-on-MOC loops see real stalls.
module data_memory_moc #(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_moc_if.slave  bus
);

  localparam int unsigned MEM_BYTES = 1 << ADDR_BITS;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic                   rw_q, rw_d;
  logic                   sgn_q, sgn_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   mis_q, mis_d;
  logic                   moc_q, moc_d;
  logic                   err_q, err_d;
  logic [31:0]            dout_q, dout_d;

  logic [7:0]             mem_q [MEM_BYTES];
  logic [7:0]             rb [4];
  logic [3:0]             we;
  logic [7:0]             wb [4];
  logic [31:0]            load_val;
  logic                   mis_in;
  logic                   unused_addr;

  assign unused_addr = ^bus.address[31:ADDR_BITS];

  assign mis_in = (bus.size == 2'b01 && bus.address[0])
               || (bus.size == 2'b10 && bus.address[1:0] != 2'b00)
               || (bus.size == 2'b11);

  // Bytes a..a+3 in big-endian order; offsets wrap modulo the memory size.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rb[i] = mem_q[addr_q + ADDR_BITS'(i)];
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & rb[0][7]}}, rb[0]};
      2'b01:   load_val = {{16{sgn_q & rb[0][7]}}, rb[0], rb[1]};
      default: load_val = {rb[0], rb[1], rb[2], rb[3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    rw_d    = rw_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    moc_d   = moc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    we      = 4'b0000;
    for (int i = 0; i < 4; i++) wb[i] = 8'h00;

    case (state_q)
      IDLE: begin
        moc_d = 1'b0;
        err_d = 1'b0;
        if (bus.mov) begin
          addr_d  = bus.address[ADDR_BITS-1:0];
          size_d  = bus.size;
          rw_d    = bus.rw;
          sgn_d   = bus.sgn;
          wdata_d = bus.data_in;
          mis_d   = mis_in;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          moc_d   = 1'b1;
          err_d   = mis_q;
          // A misaligned access completes with err but touches nothing.
          if (!mis_q) begin
            if (rw_q) begin
              dout_d = load_val;
            end else begin
              case (size_q)
                2'b00: begin
                  we    = 4'b0001;
                  wb[0] = wdata_q[7:0];
                end
                2'b01: begin
                  we    = 4'b0011;
                  wb[0] = wdata_q[15:8];
                  wb[1] = wdata_q[7:0];
                end
                default: begin
                  we    = 4'b1111;
                  wb[0] = wdata_q[31:24];
                  wb[1] = wdata_q[23:16];
                  wb[2] = wdata_q[15:8];
                  wb[3] = wdata_q[7:0];
                end
              endcase
            end
          end
        end
      end
      DONE: begin
        if (!bus.mov) begin
          state_d = IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      rw_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Array is never reset; writes only happen on the commit edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr_q + ADDR_BITS'(i)] <= wb[i];
    end
  end

  assign bus.data_out = dout_q;
  assign bus.moc      = moc_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_data_memory_moc.sv
// Self-checking bench for data_memory_moc: directed table, handshake corners,
// reset abort, wrap, and randomized traffic against a byte-array model.
module tb_data_memory_moc;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  data_memory_moc_if bus0 ();
  data_memory_moc_if bus1 ();

  data_memory_moc #(.ADDR_BITS(9), .LATENCY(2)) dut  (.clk(clk), .reset(rst_n), .bus(bus0.slave));
  data_memory_moc #(.ADDR_BITS(9), .LATENCY(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  refm [2][512];
  logic [31:0] last_ld [2];

  typedef struct {
    bit          rw;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chk_d;
    logic [31:0] exp_d;
    bit          exp_e;
  } vec_t;

  vec_t tbl [11];

  function automatic int lat_of(int d);
    return (d != 0) ? 1 : 2;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(int d, bit m, bit rw, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd);
    if (d == 0) begin
      bus0.mov = m; bus0.rw = rw; bus0.size = sz; bus0.sgn = sg; bus0.address = a; bus0.data_in = wd;
    end else begin
      bus1.mov = m; bus1.rw = rw; bus1.size = sz; bus1.sgn = sg; bus1.address = a; bus1.data_in = wd;
    end
  endtask

  function automatic logic get_moc(int d);
    return (d != 0) ? bus1.moc : bus0.moc;
  endfunction
  function automatic logic get_err(int d);
    return (d != 0) ? bus1.err : bus0.err;
  endfunction
  function automatic logic [31:0] get_dout(int d);
    return (d != 0) ? bus1.data_out : bus0.data_out;
  endfunction

  function automatic bit model_mis(logic [1:0] sz, logic [31:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  // Behavioural reference: byte array, big-endian assembly by arithmetic.
  task automatic model_apply(int d, bit rw, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd,
                             output logic [31:0] exp_d, output bit exp_e);
    int     n;
    int     base;
    longint v;
    exp_e = model_mis(sz, a);
    if (!exp_e) begin
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = int'(a % 512);
      if (rw) begin
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(refm[d][(base + i) % 512]);
        if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        last_ld[d] = 32'(v);
      end else begin
        for (int i = 0; i < n; i++) refm[d][(base + i) % 512] = 8'(wd >> (8 * (n - 1 - i)));
      end
    end
    exp_d = last_ld[d];
  endtask

  // One full handshake, entered and left at posedge+1.
  task automatic op(int d, bit rw, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd,
                    output logic [31:0] dout, output bit e, output int lat);
    drive(d, 1'b1, rw, sz, sg, a, wd);
    @(posedge clk);
    #1;
    drive(d, 1'b1, ~rw, 2'($urandom), $urandom, $urandom, $urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (get_moc(d)) begin
        lat = i;
        break;
      end
    end
    dout = get_dout(d);
    e    = get_err(d);
    drive(d, 1'b0, 1'b0, 2'd0, 1'b0, $urandom, $urandom);
    @(posedge clk);
    #1;
    check("moc_release", 32'(get_moc(d)), 32'd0);
  endtask

  task automatic run_check(int d, bit rw, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd);
    logic [31:0] exp_d, dout;
    bit          exp_e, e;
    int          lat;
    model_apply(d, rw, sz, sg, a, wd, exp_d, exp_e);
    op(d, rw, sz, sg, a, wd, dout, e, lat);
    check("latency", 32'(lat), 32'(lat_of(d)));
    check("err", 32'(e), 32'(exp_e));
    check("data_out", dout, exp_d);
  endtask

  initial begin
    logic [31:0] dout, md, a;
    bit          e, me;
    int          lat, cnt;
    logic [1:0]  sz;

    total = 0;
    bad   = 0;
    last_ld[0] = '0;
    last_ld[1] = '0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);

    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h010, 32'h0,        1'b1, 32'h000000DE, 1'b0};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h020, 32'h00008001, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 32'h020, 32'h0,        1'b1, 32'hFFFF8001, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h020, 32'h0,        1'b1, 32'h00008001, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b1, 32'h021, 32'h0,        1'b1, 32'h00000001, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h013, 32'h11223344, 1'b0, 32'h0,        1'b1};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 32'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 1'b1, 32'h011, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_moc", 32'(get_moc(d)), 32'd0);
      check("reset_err", 32'(get_err(d)), 32'd0);
      check("reset_dout", get_dout(d), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Give every byte a known value so all later reads are predictable.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 128; i++) run_check(d, 1'b0, 2'd2, 1'b0, 32'(4 * i), $urandom);

    for (int i = 0; i < 11; i++) begin
      model_apply(0, tbl[i].rw, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, md, me);
      op(0, tbl[i].rw, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, dout, e, lat);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_e));
      if (tbl[i].chk_d) check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_d);
    end

    // mov held high in DONE: moc stays up, altered inputs start nothing.
    model_apply(0, 1'b0, 2'd2, 1'b0, 32'h030, 32'hCAFEF00D, md, me);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h030, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (get_moc(0)) begin
        lat = i;
        break;
      end
    end
    check("hold_latency", 32'(lat), 32'd2);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h030, 32'h55555555);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (get_moc(0)) cnt++;
    end
    check("hold_moc_cycles", 32'(cnt), 32'd6);
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    check("hold_release", 32'(get_moc(0)), 32'd0);
    run_check(0, 1'b1, 2'd2, 1'b0, 32'h030, '0);
    check("hold_no_second", get_dout(0), 32'hCAFEF00D);

    // mov dropped during BUSY: single moc pulse, write still lands.
    model_apply(0, 1'b0, 2'd2, 1'b0, 32'h034, 32'h0BADF00D, md, me);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h034, 32'h0BADF00D);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h100, 32'h0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (get_moc(0)) cnt++;
    end
    check("drop_pulse_cycles", 32'(cnt), 32'd1);
    run_check(0, 1'b1, 2'd2, 1'b0, 32'h034, '0);
    check("drop_committed", get_dout(0), 32'h0BADF00D);

    // Reset asserted while a write is in BUSY.
    run_check(0, 1'b1, 2'd2, 1'b0, 32'h010, '0);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h040, 32'h12345678);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_moc", 32'(get_moc(0)), 32'd0);
    check("rst_async_err", 32'(get_err(0)), 32'd0);
    check("rst_async_dout", get_dout(0), 32'd0);
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    #2;
    rst_n = 1'b1;
    last_ld[0] = '0;
    last_ld[1] = '0;
    @(posedge clk);
    #1;
    run_check(0, 1'b1, 2'd2, 1'b0, 32'h040, '0);

    // Top-of-memory word on the LATENCY=1 instance, read back through an alias.
    run_check(1, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'hA1B2C3D4);
    run_check(1, 1'b1, 2'd2, 1'b0, 32'h3FC, '0);
    check("wrap_alias", get_dout(1), 32'hA1B2C3D4);
    run_check(1, 1'b1, 2'd1, 1'b1, 32'h1FE, '0);
    check("wrap_half", get_dout(1), 32'hFFFFC3D4);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        sz = 2'($urandom_range(0, 3));
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
        run_check(d, 1'($urandom), sz, 1'($urandom), a, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
